// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin packet arbiter with a one-beat output register.
// A packet owner keeps the channel until its last beat is accepted.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid[i]      requester i offers a beat
//   req_last[i]       that beat ends requester i's packet
//   req_data          requester i at [DATA_LEN*(i+1)-1 -: DATA_LEN]
//   req_ready[i]      requester i's beat is accepted this cycle
//   out_valid/ready   registered output handshake
//   out_data/last     registered payload and last flag
//   grant_key         index of current or most recent owner
//   locked            high while a packet owner holds the channel
module rr_arbiter #(
   parameter int NR_REQ   = 4,
   parameter int KEY_LEN  = 2,
   parameter int DATA_LEN = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NR_REQ-1:0]          req_valid,
   input  logic [NR_REQ-1:0]          req_last,
   input  logic [NR_REQ*DATA_LEN-1:0] req_data,
   output logic [NR_REQ-1:0]          req_ready,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_LEN-1:0]        out_data,
   output logic                       out_last,
   output logic [KEY_LEN-1:0]         grant_key,
   output logic                       locked
);

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [KEY_LEN-1:0]   ptr;
   logic                 slot_free;
   logic                 any_valid;
   logic [KEY_LEN-1:0]   win;
   logic                 accept;
   logic [KEY_LEN-1:0]   sel;
   logic [DATA_LEN-1:0]  sel_data;
   logic                 sel_last;

   // The output register can take a beat when empty or draining now.
   assign slot_free = !out_valid || out_ready;
   assign locked    = (state == LOCK);

   // Round-robin search starting just after the last winner.
   always_comb begin
      int c;
      win       = '0;
      any_valid = 1'b0;
      c         = 0;
      for (int k = 1; k <= NR_REQ; k++) begin
         c = (int'(ptr) + k) % NR_REQ;
         if (!any_valid && req_valid[c]) begin
            any_valid = 1'b1;
            win       = KEY_LEN'(c);
         end
      end
   end

   // Grant decision; no dependence on req_data. Held off in reset.
   always_comb begin
      accept    = 1'b0;
      sel       = win;
      req_ready = '0;
      if (rst_n) begin
         unique case (state)
            IDLE: begin
               if (slot_free && any_valid) begin
                  accept = 1'b1;
                  sel    = win;
               end
            end
            LOCK: begin
               if (slot_free && req_valid[grant_key]) begin
                  accept = 1'b1;
                  sel    = grant_key;
               end
            end
            default: begin
               accept = 1'b0;
            end
         endcase
      end
      if (accept) begin
         req_ready[sel] = 1'b1;
      end
   end

   // Payload mux for the selected requester.
   always_comb begin
      sel_data = '0;
      sel_last = 1'b0;
      for (int i = 0; i < NR_REQ; i++) begin
         if (sel == KEY_LEN'(i)) begin
            sel_data = req_data[DATA_LEN*i +: DATA_LEN];
            sel_last = req_last[i];
         end
      end
   end

   // Next state: a non-last beat opens a packet, a last beat closes it.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (accept && !sel_last) begin
               state_nxt = LOCK;
            end
         end
         LOCK: begin
            if (accept && sel_last) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Pointer starts at NR_REQ-1 so requester 0 wins first after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= KEY_LEN'(NR_REQ - 1);
         grant_key <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_last  <= sel_last;
            grant_key <= sel;
            if (state == IDLE) begin
               ptr <= sel;
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: directed vectors for rr_arbiter with a packet-level
// reference model checked on every falling clock edge.
module tb_rr_arbiter;

   localparam int NR = 4;
   localparam int DL = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [NR-1:0] req_valid;
   logic [NR-1:0] req_last;
   logic [NR*DL-1:0] req_data;
   logic [NR-1:0] req_ready;
   logic          out_valid;
   logic          out_ready;
   logic [DL-1:0] out_data;
   logic          out_last;
   logic [1:0]    grant_key;
   logic          locked;

   int total = 0;
   int bad = 0;

   rr_arbiter #(
      .NR_REQ(NR),
      .KEY_LEN(2),
      .DATA_LEN(DL)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req_valid(req_valid),
      .req_last(req_last),
      .req_data(req_data),
      .req_ready(req_ready),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .out_last(out_last),
      .grant_key(grant_key),
      .locked(locked)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: owner is -1 when no packet is open.
   int m_owner = -1;
   int m_ptr   = NR - 1;
   int m_key   = 0;
   int m_ov    = 0;
   int m_od    = 0;
   int m_ol    = 0;
   int p_owner = -1;
   int p_ptr   = NR - 1;
   int p_key   = 0;
   int p_ov    = 0;
   int p_od    = 0;
   int p_ol    = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_owner <= -1;
         m_ptr   <= NR - 1;
         m_key   <= 0;
         m_ov    <= 0;
         m_od    <= 0;
         m_ol    <= 0;
      end else begin
         m_owner <= p_owner;
         m_ptr   <= p_ptr;
         m_key   <= p_key;
         m_ov    <= p_ov;
         m_od    <= p_od;
         m_ol    <= p_ol;
      end
   end

   always @(negedge clk) begin
      int acc;
      int c;
      logic slot;
      logic [NR-1:0] exp_rdy;
      acc = -1;
      exp_rdy = '0;
      slot = (m_ov == 0) || out_ready;
      if (rst_n && slot) begin
         if (m_owner >= 0) begin
            if (req_valid[m_owner]) acc = m_owner;
         end else begin
            for (int k = 1; k <= NR; k++) begin
               c = (m_ptr + k) % NR;
               if (acc < 0 && req_valid[c]) acc = c;
            end
         end
      end
      if (acc >= 0) exp_rdy[acc] = 1'b1;
      chk("m_out_valid", int'(out_valid), m_ov);
      chk("m_out_data", int'(out_data), m_od);
      chk("m_out_last", int'(out_last), m_ol);
      chk("m_grant_key", int'(grant_key), m_key);
      chk("m_locked", int'(locked), int'(m_owner >= 0));
      chk("m_req_ready", int'(req_ready), int'(exp_rdy));
      p_owner <= m_owner;
      p_ptr   <= m_ptr;
      p_key   <= m_key;
      p_ov    <= m_ov;
      p_od    <= m_od;
      p_ol    <= m_ol;
      if (acc >= 0) begin
         p_ov  <= 1;
         p_od  <= int'(req_data[DL*acc +: DL]);
         p_ol  <= int'(req_last[acc]);
         p_key <= acc;
         if (m_owner < 0) begin
            p_ptr   <= acc;
            p_owner <= req_last[acc] ? -1 : acc;
         end else if (req_last[acc]) begin
            p_owner <= -1;
         end
      end else if (out_ready) begin
         p_ov <= 0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req_valid = '0;
      req_last  = '0;
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic put(input int i, input logic [DL-1:0] v);
      req_data[DL*i +: DL] = v;
   endtask

   int s1_key[5] = '{0, 1, 2, 3, 0};
   int s2_key[4] = '{0, 2, 0, 2};

   initial begin
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      out_ready = 1'b0;
      #1 rst_n = 1'b0;
      req_valid = 4'hF;
      step();
      chk("rst_ready", int'(req_ready), 0);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_key", int'(grant_key), 0);
      chk("rst_locked", int'(locked), 0);
      chk("rst_data", int'(out_data), 0);
      step();
      rst_n = 1'b1;
      req_valid = '0;

      // all requesters, single-beat packets
      for (int i = 0; i < NR; i++) put(i, 8'(8'hA0 + i));
      req_valid = 4'hF;
      req_last  = 4'hF;
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("s1_key", int'(grant_key), s1_key[k]);
         chk("s1_valid", int'(out_valid), 1);
         chk("s1_data", int'(out_data), 'hA0 + s1_key[k]);
      end

      // sparse requesters 0 and 2
      do_reset();
      req_valid = 4'b0101;
      req_last  = 4'hF;
      for (int k = 0; k < 4; k++) begin
         #1 chk("s2_blocked", int'(req_ready & 4'b1010), 0);
         step();
         chk("s2_key", int'(grant_key), s2_key[k]);
      end

      // 3-beat packet from 1 while 0 waits
      do_reset();
      req_valid = 4'b0010;
      req_last  = 4'b0000;
      put(1, 8'h11);
      step();
      chk("s3_b1_key", int'(grant_key), 1);
      chk("s3_b1_lock", int'(locked), 1);
      chk("s3_b1_data", int'(out_data), 'h11);
      req_valid = 4'b0011;
      req_last  = 4'b0001;
      put(0, 8'h0A);
      put(1, 8'h12);
      step();
      chk("s3_b2_key", int'(grant_key), 1);
      chk("s3_b2_lock", int'(locked), 1);
      chk("s3_b2_data", int'(out_data), 'h12);
      req_last = 4'b0011;
      put(1, 8'h13);
      step();
      chk("s3_b3_key", int'(grant_key), 1);
      chk("s3_b3_lock", int'(locked), 0);
      chk("s3_b3_last", int'(out_last), 1);
      chk("s3_b3_data", int'(out_data), 'h13);
      step();
      chk("s3_next_key", int'(grant_key), 0);
      chk("s3_next_data", int'(out_data), 'h0A);

      // backpressure
      do_reset();
      out_ready = 1'b0;
      req_valid = 4'b0001;
      req_last  = 4'b0001;
      put(0, 8'h55);
      step();
      chk("s4_valid", int'(out_valid), 1);
      chk("s4_data", int'(out_data), 'h55);
      put(0, 8'h66);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("s4_hold", int'(out_data), 'h55);
         chk("s4_noready", int'(req_ready), 0);
      end
      out_ready = 1'b1;
      #1 chk("s4_ready", int'(req_ready), 1);
      step();
      chk("s4_load", int'(out_data), 'h66);
      chk("s4_valid2", int'(out_valid), 1);

      // owner stalls inside a packet
      do_reset();
      out_ready = 1'b1;
      req_valid = 4'b0100;
      req_last  = 4'b0000;
      put(2, 8'h70);
      step();
      chk("s5_lock", int'(locked), 1);
      chk("s5_key", int'(grant_key), 2);
      req_valid = 4'b1011;
      req_last  = 4'hF;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("s5_stall_lock", int'(locked), 1);
         chk("s5_stall_ready", int'(req_ready), 0);
         chk("s5_stall_valid", int'(out_valid), 0);
      end
      req_valid = 4'hF;
      put(2, 8'h77);
      #1 chk("s5_resume_ready", int'(req_ready), 'b0100);
      step();
      chk("s5_resume_data", int'(out_data), 'h77);
      chk("s5_resume_lock", int'(locked), 0);
      step();
      chk("s5_next_key", int'(grant_key), 3);

      // asynchronous reset mid-packet
      do_reset();
      req_valid = 4'b0010;
      req_last  = 4'b0000;
      step();
      chk("s6_lock", int'(locked), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("s6_async_valid", int'(out_valid), 0);
      chk("s6_async_lock", int'(locked), 0);
      chk("s6_async_ready", int'(req_ready), 0);
      step();
      rst_n = 1'b1;
      req_valid = 4'hF;
      req_last  = 4'hF;
      step();
      chk("s6_first_key", int'(grant_key), 0);
      chk("s6_first_lock", int'(locked), 0);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 SHALL have parameter NR_REQ, default 4, meaning the number of requesters sharing the output channel.
REQ-002 SHALL have parameter KEY_LEN, default 2, meaning the grant key width; legal values satisfy 2^KEY_LEN >= NR_REQ.
REQ-003 SHALL have parameter DATA_LEN, default 8, meaning the payload width per requester.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, all state on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port req_valid, input, NR_REQ bits: bit i means requester i offers a beat.
REQ-007 SHALL have port req_last, input, NR_REQ bits: bit i means requester i's beat ends its packet.
REQ-008 SHALL have port req_data, input, NR_REQ*DATA_LEN bits: requester i occupies bits [DATA_LEN*(i+1)-1 -: DATA_LEN].
REQ-009 SHALL have port req_ready, output, NR_REQ bits: bit i means requester i's beat is accepted this cycle.
REQ-010 SHALL have port out_valid, output, 1 bit: the registered output beat is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: the downstream consumer takes the output beat.
REQ-012 SHALL have port out_data, output, DATA_LEN bits: the registered payload.
REQ-013 SHALL have port out_last, output, 1 bit: the registered last flag.
REQ-014 SHALL have port grant_key, output, KEY_LEN bits: the index of the current or most recent owner, usable as a MuxKey select.
REQ-015 SHALL have port locked, output, 1 bit: high while in the LOCK state.

Function
REQ-016 SHALL define slot_free = !out_valid || out_ready; no beat is accepted unless slot_free is high.
REQ-017 SHALL implement states IDLE and LOCK, plus a round-robin pointer ptr of KEY_LEN bits.
REQ-018 In IDLE with slot_free and any req_valid high, SHALL select winner w as the first valid index in order ptr+1, ptr+2, ... modulo NR_REQ.
REQ-019 In IDLE, SHALL drive req_ready[w]=1 combinationally for that winner only; all other req_ready bits are 0.
REQ-020 On acceptance, SHALL register out_data from the selected req_data slice and out_last from req_last[w], set out_valid=1, and update grant_key<=w and ptr<=w.
REQ-021 After an IDLE acceptance, SHALL stay in IDLE if req_last[w]=1 and go to LOCK if req_last[w]=0.
REQ-022 In LOCK, SHALL drive req_ready[grant_key] = slot_free && req_valid[grant_key]; all other req_ready bits are 0.
REQ-023 In LOCK, SHALL ignore other requesters regardless of their req_valid.
REQ-024 In LOCK, an accepted beat with req_last=1 SHALL return the block to IDLE; ptr is unchanged.
REQ-025 SHALL clear out_valid on out_ready && out_valid when no new beat is accepted in the same cycle.
REQ-026 When a drain and an accept happen in the same cycle, SHALL load the new beat with out_valid staying 1, giving one beat per cycle throughput.
REQ-027 When the owner deasserts req_valid in LOCK, SHALL make no transfer and hold the lock with no timeout.
REQ-028 SHALL keep out_data and out_last stable while out_valid && !out_ready.
REQ-029 SHALL never produce a grant_key value >= NR_REQ; ptr wraps from NR_REQ-1 to 0.
REQ-030 SHALL have req_ready depend only on state, ptr, grant_key, out_valid, out_ready and req_valid, with no path from req_data.

Reset
REQ-031 On rst_n=0, SHALL immediately set state=IDLE, ptr=NR_REQ-1, grant_key=0, out_valid=0, out_data=0 and out_last=0.
REQ-032 During reset, SHALL hold req_ready=0.
REQ-033 After reset, SHALL give requester 0 top priority at the first arbitration.
REQ-034 Reset asserted mid-packet SHALL abandon the lock; the partially sent packet is not resumed.

Verification
REQ-035 SHALL cover: after reset, req_valid=4'b1111, all last=1, out_ready=1 -> grant_key sequence 0,1,2,3,0 on consecutive cycles, out_valid continuously 1.
REQ-036 SHALL cover: req_valid=4'b0101, last=1, out_ready=1 -> grants alternate 0,2,0,2; requesters 1 and 3 never get req_ready.
REQ-037 SHALL cover: requester 1 sends a 3-beat packet (last on beat 3) while requester 0 is continuously valid -> locked=1 for beats 1-2; requester 0 is granted only after beat 3.
REQ-038 SHALL cover: out_ready=0 with a beat held -> out_data is unchanged and req_ready=0; one cycle after out_ready rises, the next beat loads.
REQ-039 SHALL cover: in LOCK, the owner drops req_valid for 5 cycles -> no transfers, locked stays 1, others stay blocked, and transfer resumes when req_valid returns.
REQ-040 SHALL cover: rst_n pulsed low mid-packet -> out_valid=0 and locked=0 asynchronously, and the next grant goes to requester 0.
